// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder. One full-adder cell plus a carry flip-flop is
//   reused over WIDTH clocks, LSB first. The parallel result and final carry
//   are registered at the last bit and held until the next completion.
//
// Ports
//   clk       rising-edge clock
//   resetN    asynchronous active-low reset
//   start     request, sampled only while idle
//   a, b      operands, captured when start is accepted
//   carryIn   initial carry, captured when start is accepted
//   busy      high while an addition is in progress or completing
//   done      one-cycle pulse, sum/carryOut valid
//   sum       registered result
//   carryOut  registered final carry
// ---------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryOut
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc;

    logic             bit_s;
    logic             bit_c;
    logic [WIDTH-1:0] acc_next;
    logic             last_bit;
    logic             accept;

    // Full-adder cell on the current LSBs.
    always_comb begin
        bit_s = op_a[0] ^ op_b[0] ^ carry;
        bit_c = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
    end

    // Shift-then-insert form stays legal when WIDTH is 1.
    always_comb begin
        acc_next           = acc >> 1;
        acc_next[WIDTH-1]  = bit_s;
    end

    always_comb begin
        last_bit = (state == SHIFT) && (cnt == LAST_CNT);
        accept   = (state == IDLE) && start;
    end

    // State register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)    state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:                  state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Datapath
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            op_a     <= '0;
            op_b     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            sum      <= '0;
            carryOut <= 1'b0;
        end else if (accept) begin
            op_a  <= a;
            op_b  <= b;
            carry <= carryIn;
            cnt   <= '0;
            acc   <= '0;
        end else if (state == SHIFT) begin
            op_a  <= op_a >> 1;
            op_b  <= op_b >> 1;
            carry <= bit_c;
            cnt   <= cnt + CNT_W'(1);
            acc   <= acc_next;
            if (last_bit) begin
                sum      <= acc_next;
                carryOut <= bit_c;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic       clk;
    logic       resetN;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int vectors;
    int miscompares;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .resetN   (resetN),
        .start    (start8),
        .a        (a8),
        .b        (b8),
        .carryIn  (cin8),
        .busy     (busy8),
        .done     (done8),
        .sum      (sum8),
        .carryOut (cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk      (clk),
        .resetN   (resetN),
        .start    (start1),
        .a        (a1),
        .b        (b1),
        .carryIn  (cin1),
        .busy     (busy1),
        .done     (done1),
        .sum      (sum1),
        .carryOut (cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 8-bit addition with full timing and hold checks.
    task automatic add8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        logic [8:0] expv;
        logic [8:0] held;
        int         n;
        bit         seen;
        expv = 9'(av) + 9'(bv) + 9'(cv);
        held = {cout8, sum8};
        a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        // Operands may change freely after capture.
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        vectors++;
        if (busy8 !== 1'b1) begin
            miscompares++;
            $display("FAIL add8_busy_rise got=%b exp=1", busy8);
        end
        n = 0; seen = 0;
        while (!seen && n < 40) begin
            tick();
            n++;
            if (done8 === 1'b1) begin
                seen = 1;
            end else begin
                vectors++;
                if ({cout8, sum8} !== held || busy8 !== 1'b1) begin
                    miscompares++;
                    $display("FAIL add8_shift_hold cyc=%0d got=%h busy=%b exp=%h busy=1", n, {cout8, sum8}, busy8, held);
                end
            end
        end
        vectors++;
        if (!seen || n != 8) begin
            miscompares++;
            $display("FAIL add8_latency got=%0d seen=%0d exp=8", n, seen);
        end
        vectors++;
        if ({cout8, sum8} !== expv) begin
            miscompares++;
            $display("FAIL add8_result a=%h b=%h c=%b got=%h exp=%h", av, bv, cv, {cout8, sum8}, expv);
        end
        tick();
        vectors++;
        if (done8 !== 1'b0 || busy8 !== 1'b0 || {cout8, sum8} !== expv) begin
            miscompares++;
            $display("FAIL add8_after_done done=%b busy=%b res=%h exp done=0 busy=0 res=%h", done8, busy8, {cout8, sum8}, expv);
        end
    endtask

    task automatic test_reset();
        resetN = 1'b1;
        start8 = 0; a8 = '0; b8 = '0; cin8 = 0;
        start1 = 0; a1 = '0; b1 = '0; cin1 = 0;
        #1 resetN = 1'b0;
        #1;
        vectors++;
        if ({busy8, done8, cout8, sum8} !== 11'd0 || {busy1, done1, cout1, sum1} !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_state got8=%b got1=%b exp=0", {busy8, done8, cout8, sum8}, {busy1, done1, cout1, sum1});
        end
        tick();
        tick();
        resetN = 1'b1;
        tick();
        vectors++;
        if ({busy8, done8, cout8, sum8} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_release got=%b exp=0", {busy8, done8, cout8, sum8});
        end
    endtask

    task automatic test_directed();
        add8(8'h5A, 8'h3C, 1'b0);
        add8(8'hFF, 8'h01, 1'b0);
        add8(8'hFF, 8'hFF, 1'b1);
        add8(8'h00, 8'h00, 1'b0);
    endtask

    task automatic test_ignored_start();
        int  pulses;
        logic [8:0] res;
        a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        start8 = 1'b1; a8 = 8'hF0;
        tick();
        start8 = 1'b0;
        pulses = 0; res = '1;
        for (int i = 0; i < 20; i++) begin
            if (done8 === 1'b1) begin
                pulses++;
                res = {cout8, sum8};
            end
            tick();
        end
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL ignored_start_pulses got=%0d exp=1", pulses);
        end
        vectors++;
        if (res !== 9'h002) begin
            miscompares++;
            $display("FAIL ignored_start_result got=%h exp=002", res);
        end
        vectors++;
        if (busy8 !== 1'b0) begin
            miscompares++;
            $display("FAIL ignored_start_idle busy=%b exp=0", busy8);
        end
    endtask

    task automatic test_async_reset();
        int pulses;
        a8 = 8'h77; b8 = 8'h11; cin8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        #2 resetN = 1'b0;
        #1;
        vectors++;
        if ({busy8, done8, cout8, sum8} !== 11'd0) begin
            miscompares++;
            $display("FAIL async_reset_immediate got=%b exp=0", {busy8, done8, cout8, sum8});
        end
        tick();
        vectors++;
        if ({busy8, done8, cout8, sum8} !== 11'd0) begin
            miscompares++;
            $display("FAIL async_reset_held got=%b exp=0", {busy8, done8, cout8, sum8});
        end
        resetN = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 === 1'b1 || busy8 !== 1'b0) pulses++;
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL async_reset_no_done got=%0d exp=0", pulses);
        end
        add8(8'hC8, 8'h64, 1'b1);
    endtask

    task automatic test_width1();
        logic [1:0] expv;
        for (int i = 0; i < 8; i++) begin
            a1 = 1'(i >> 2); b1 = 1'(i >> 1); cin1 = 1'(i);
            expv = 2'(a1) + 2'(b1) + 2'(cin1);
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            vectors++;
            if (busy1 !== 1'b1 || done1 !== 1'b0) begin
                miscompares++;
                $display("FAIL w1_busy i=%0d busy=%b done=%b exp busy=1 done=0", i, busy1, done1);
            end
            tick();
            vectors++;
            if (done1 !== 1'b1 || {cout1, sum1} !== expv) begin
                miscompares++;
                $display("FAIL w1_result i=%0d done=%b got=%b exp done=1 res=%b", i, done1, {cout1, sum1}, expv);
            end
            tick();
            vectors++;
            if (done1 !== 1'b0 || busy1 !== 1'b0) begin
                miscompares++;
                $display("FAIL w1_idle i=%0d done=%b busy=%b exp=0", i, done1, busy1);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            add8(8'($urandom), 8'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] expv;
        logic [8:0] last;
        int         n;
        bit         seen;
        tick();
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        expv = 9'(a8) + 9'(b8) + 9'(cin8);
        last = {cout8, sum8};
        start8 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n = 0; seen = 0;
            while (!seen && n < 30) begin
                tick();
                n++;
                if (done8 === 1'b1) begin
                    seen = 1;
                end else begin
                    vectors++;
                    if ({cout8, sum8} !== last) begin
                        miscompares++;
                        $display("FAIL b2b_hold k=%0d got=%h exp=%h", k, {cout8, sum8}, last);
                    end
                end
            end
            vectors++;
            if (!seen || n != ((k == 0) ? 9 : 10)) begin
                miscompares++;
                $display("FAIL b2b_interval k=%0d got=%0d exp=%0d", k, n, (k == 0) ? 9 : 10);
            end
            vectors++;
            if ({cout8, sum8} !== expv) begin
                miscompares++;
                $display("FAIL b2b_result k=%0d got=%h exp=%h", k, {cout8, sum8}, expv);
            end
            last = expv;
            // Next capture happens two edges after this done cycle.
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            expv = 9'(a8) + 9'(b8) + 9'(cin8);
        end
        start8 = 1'b0;
        tick();
        tick();
        vectors++;
        if (busy8 !== 1'b0 || {cout8, sum8} !== last) begin
            miscompares++;
            $display("FAIL b2b_stop busy=%b res=%h exp busy=0 res=%h", busy8, {cout8, sum8}, last);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_directed();
        test_ignored_start();
        test_async_reset();
        test_width1();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
